// File: rtl/ll8_to_fifo36.sv
// Packs an 8-bit LocalLink byte stream big-endian into 36-bit fifo36 words
// carrying SOF, EOF and occupancy flags, with a single registered output word.
module ll8_to_fifo36 (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ll_data,
  input  logic        ll_sof,
  input  logic        ll_eof,
  input  logic        ll_src_rdy_i,
  output logic        ll_dst_rdy_o,
  output logic [35:0] dataout,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic        error_o
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t      r_state, w_nextState;
  logic [31:0] r_acc, w_nextAcc;
  logic [1:0]  r_bc, w_nextBc;
  logic        r_sofPend, w_nextSofPend;
  logic [35:0] r_dataout;
  logic        r_srcRdy;
  logic        r_error;

  logic        w_accept;
  logic        w_emit;
  logic        w_frameErr;
  logic [1:0]  w_lane;
  logic [2:0]  w_count;
  logic [31:0] w_base;
  logic [31:0] w_merged;
  logic        w_wordSof;

  // Input may advance whenever the output slot is empty or draining this cycle.
  assign ll_dst_rdy_o = ~reset & (~r_srcRdy | dst_rdy_i);
  assign w_accept     = ll_src_rdy_i & ll_dst_rdy_o;

  assign dataout   = r_dataout;
  assign src_rdy_o = r_srcRdy;
  assign error_o   = r_error;

  always_comb begin
    w_nextState   = r_state;
    w_nextAcc     = r_acc;
    w_nextBc      = r_bc;
    w_nextSofPend = r_sofPend;
    w_emit        = 1'b0;
    w_frameErr    = 1'b0;

    // An SOF byte always starts a fresh word at lane 0, discarding any partial.
    w_lane    = ll_sof ? 2'd0 : r_bc;
    w_base    = ll_sof ? 32'd0 : r_acc;
    w_merged  = w_base | ({ll_data, 24'd0} >> {w_lane, 3'b000});
    w_count   = {1'b0, w_lane} + 3'd1;
    w_wordSof = ll_sof | r_sofPend;

    if (w_accept) begin
      if (r_state == IDLE && !ll_sof) begin
        w_frameErr = 1'b1;
      end else begin
        if (r_state == PKT && ll_sof) begin
          w_frameErr = 1'b1;
        end
        w_emit      = (w_count == 3'd4) | ll_eof;
        w_nextState = ll_eof ? IDLE : PKT;
        if (w_emit) begin
          w_nextAcc     = 32'd0;
          w_nextBc      = 2'd0;
          w_nextSofPend = 1'b0;
        end else begin
          w_nextAcc     = w_merged;
          w_nextBc      = w_count[1:0];
          w_nextSofPend = w_wordSof;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= 32'd0;
      r_bc      <= 2'd0;
      r_sofPend <= 1'b0;
      r_dataout <= 36'd0;
      r_srcRdy  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_acc     <= w_nextAcc;
      r_bc      <= w_nextBc;
      r_sofPend <= w_nextSofPend;
      r_error   <= w_frameErr;
      // Occupancy wraps so a full word reports 0.
      if (w_emit) begin
        r_dataout <= {w_count[1:0], ll_eof, w_wordSof, w_merged};
        r_srcRdy  <= 1'b1;
      end else if (dst_rdy_i) begin
        r_srcRdy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ll8_to_fifo36.sv
// Self-checking bench for ll8_to_fifo36: directed cases plus randomized packets
// scored against a packet-level byte-queue reference model.
module tb_ll8_to_fifo36;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ll_data;
  logic        ll_sof;
  logic        ll_eof;
  logic        ll_src_rdy_i;
  logic        ll_dst_rdy_o;
  logic [35:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_i;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  logic [35:0] expQ[$];
  logic [35:0] gotQ[$];
  logic [7:0]  pkt[$];
  bit          inPkt = 0;
  int          expErr = 0;
  int          errPulses = 0;
  int          srcHighCycles = 0;
  bit          bpRandom = 0;
  logic        bpValue = 1'b1;
  bit          prevHold = 0;
  logic [35:0] prevData = 36'd0;

  ll8_to_fifo36 dut (
    .clk          (clk),
    .reset        (reset),
    .ll_data      (ll_data),
    .ll_sof       (ll_sof),
    .ll_eof       (ll_eof),
    .ll_src_rdy_i (ll_src_rdy_i),
    .ll_dst_rdy_o (ll_dst_rdy_o),
    .dataout      (dataout),
    .src_rdy_o    (src_rdy_o),
    .dst_rdy_i    (dst_rdy_i),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [35:0] actual, input logic [35:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // A word covers packet bytes [base, base+4) of the current packet, big-endian.
  function automatic logic [35:0] buildWord(int base, bit sof, bit eof);
    int n;
    logic [31:0] d;
    n = pkt.size() - base;
    d = 32'd0;
    for (int k = 0; k < 4; k++) d = {d[23:0], (k < n) ? pkt[base + k] : 8'h00};
    return {2'(n % 4), eof, sof, d};
  endfunction

  task automatic modelByte(input logic [7:0] d, input logic sof, input logic eof);
    int base;
    if (!inPkt && !sof) begin
      expErr++;
      return;
    end
    if (inPkt && sof) expErr++;
    if (sof) begin
      pkt.delete();
      inPkt = 1;
    end
    pkt.push_back(d);
    base = ((pkt.size() - 1) / 4) * 4;
    if ((pkt.size() % 4 == 0) || eof) expQ.push_back(buildWord(base, base == 0, eof));
    if (eof) inPkt = 0;
  endtask

  // Monitor samples on the falling edge, predicting what the next rising edge commits.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("dst_rdy in reset", 36'(ll_dst_rdy_o), 36'd0);
      expQ.delete();
      pkt.delete();
      inPkt = 0;
      prevHold = 0;
    end else begin
      checkOutput("ll_dst_rdy", 36'(ll_dst_rdy_o), 36'(!src_rdy_o || dst_rdy_i));
      if (prevHold) begin
        checkOutput("hold data", dataout, prevData);
        checkOutput("hold valid", 36'(src_rdy_o), 36'd1);
      end
      if (src_rdy_o) srcHighCycles++;
      if (error_o) errPulses++;
      if (src_rdy_o && dst_rdy_i) begin
        gotQ.push_back(dataout);
        if (expQ.size() == 0) checkOutput("expected queue", 36'(expQ.size()), 36'd1);
        else checkOutput("word", dataout, expQ.pop_front());
      end
      prevHold = src_rdy_o && !dst_rdy_i;
      prevData = dataout;
      if (ll_src_rdy_i && ll_dst_rdy_o) modelByte(ll_data, ll_sof, ll_eof);
    end
  end

  initial begin
    dst_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dst_rdy_i = bpRandom ? ($urandom_range(0, 3) != 0) : bpValue;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] d, input logic sof, input logic eof);
    bit took;
    took = 0;
    ll_data = d;
    ll_sof = sof;
    ll_eof = eof;
    ll_src_rdy_i = 1'b1;
    for (int i = 0; i < 300 && !took; i++) begin
      @(negedge clk);
      took = ll_dst_rdy_o;
      @(posedge clk);
      #1;
    end
    if (!took) checkOutput("accept timeout", 36'(took), 36'd1);
    ll_src_rdy_i = 1'b0;
    ll_sof = 1'b0;
    ll_eof = 1'b0;
  endtask

  task automatic sendPacket(input logic [7:0] start, input logic [7:0] step, input int n, input bit withEof);
    for (int i = 0; i < n; i++)
      applyStimulus(8'(start + step * 8'(i)), i == 0, withEof && (i == n - 1));
  endtask

  task automatic waitDrain();
    int i;
    for (i = 0; i < 500; i++) begin
      if (expQ.size() == 0 && !src_rdy_o) break;
      @(posedge clk);
      #1;
    end
    if (i == 500) checkOutput("drain timeout", 36'(expQ.size()), 36'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int len;
    bit trunc;
    reset = 1'b1;
    ll_data = 8'h00;
    ll_sof = 1'b0;
    ll_eof = 1'b0;
    ll_src_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset dataout", dataout, 36'd0);
    checkOutput("reset src_rdy", 36'(src_rdy_o), 36'd0);
    checkOutput("reset error", 36'(error_o), 36'd0);
    checkOutput("reset ll_dst_rdy", 36'(ll_dst_rdy_o), 36'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    gotQ.delete(); e0 = errPulses;
    sendPacket(8'h01, 8'h01, 5, 1);
    waitDrain();
    checkOutput("p5 count", 36'(gotQ.size()), 36'd2);
    checkOutput("p5 w0", gotQ[0], 36'h1_0102_0304);
    checkOutput("p5 w1", gotQ[1], 36'h6_0500_0000);
    checkOutput("p5 err", 36'(errPulses - e0), 36'd0);

    gotQ.delete(); srcHighCycles = 0;
    sendPacket(8'hAA, 8'h00, 1, 1);
    waitDrain();
    checkOutput("p1 w0", gotQ[0], 36'h7_AA00_0000);
    checkOutput("p1 valid cycles", 36'(srcHighCycles), 36'd1);

    gotQ.delete();
    sendPacket(8'h11, 8'h11, 4, 1);
    sendPacket(8'h11, 8'h11, 6, 1);
    waitDrain();
    checkOutput("p4 w0", gotQ[0], 36'h3_1122_3344);
    checkOutput("p6 w0", gotQ[1], 36'h1_1122_3344);
    checkOutput("p6 w1", gotQ[2], 36'hA_5566_0000);

    gotQ.delete();
    fork
      sendPacket(8'h01, 8'h01, 12, 1);
      begin
        for (int i = 0; i < 100 && gotQ.size() < 1; i++) begin
          @(posedge clk);
          #1;
        end
        bpValue = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        checkOutput("bp held valid", 36'(src_rdy_o), 36'd1);
        checkOutput("bp ll_dst_rdy", 36'(ll_dst_rdy_o), 36'd0);
        checkOutput("bp held data", dataout, 36'h0_0506_0708);
        bpValue = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp count", 36'(gotQ.size()), 36'd3);
    checkOutput("bp w0", gotQ[0], 36'h1_0102_0304);
    checkOutput("bp w1", gotQ[1], 36'h0_0506_0708);
    checkOutput("bp w2", gotQ[2], 36'h2_090A_0B0C);

    gotQ.delete(); e0 = errPulses;
    applyStimulus(8'h99, 1'b0, 1'b0);
    waitDrain();
    checkOutput("stray words", 36'(gotQ.size()), 36'd0);
    checkOutput("stray err", 36'(errPulses - e0), 36'd1);

    gotQ.delete(); e0 = errPulses;
    sendPacket(8'hA1, 8'h01, 2, 0);
    sendPacket(8'hB1, 8'h01, 3, 1);
    waitDrain();
    checkOutput("midsof count", 36'(gotQ.size()), 36'd1);
    checkOutput("midsof w0", gotQ[0], 36'hF_B1B2_B300);
    checkOutput("midsof err", 36'(errPulses - e0), 36'd1);

    sendPacket(8'hC1, 8'h01, 2, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset src_rdy", 36'(src_rdy_o), 36'd0);
    checkOutput("midreset dataout", dataout, 36'd0);
    reset = 1'b0;
    gotQ.delete(); e0 = errPulses;
    sendPacket(8'hD1, 8'h01, 4, 1);
    waitDrain();
    checkOutput("postreset w0", gotQ[0], 36'h3_D1D2_D3D4);
    checkOutput("postreset err", 36'(errPulses - e0), 36'd0);

    bpRandom = 1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 9) == 0) applyStimulus(8'($urandom), 1'b0, 1'b0);
      len = $urandom_range(1, 9);
      trunc = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < len; i++) begin
        applyStimulus(8'($urandom), i == 0, !trunc && (i == len - 1));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    bpRandom = 0;
    bpValue = 1'b1;
    waitDrain();
    checkOutput("error total", 36'(errPulses), 36'(expErr));
    checkOutput("leftover words", 36'(expQ.size()), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
